// File: rtl/div_pkg.sv
// Shared types and sizing for the sequential restoring divider.
// Default divisor width; dividend/quotient are twice that.
package div_pkg;
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  localparam int DIV_N     = 4;
  localparam int DIV_W     = 2 * DIV_N;
  localparam int DIV_CNT_W = $clog2(DIV_W + 1);
endpackage

// File: rtl/div_step.sv
// One restoring division step: shift in a dividend bit, trial-subtract the divisor.
// Purely combinational.
module div_step
  import div_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic [N-1:0] i_pr,
  input  logic         i_bit,
  input  logic [N-1:0] i_divisor,
  output logic [N:0]   o_pr,
  output logic         o_qbit
);
  logic [N:0] w_shift;
  logic [N:0] w_trial;

  // Partial remainder stays below the divisor, so its top bit is never needed here.
  always_comb begin
    w_shift = {i_pr, i_bit};
    w_trial = w_shift - {1'b0, i_divisor};
    o_qbit  = ~w_trial[N];
    o_pr    = o_qbit ? w_trial : w_shift;
  end
endmodule

// File: rtl/wallace_tree_divider.sv
// Restoring divider, one quotient bit per cycle, start/busy/done handshake (latency 2N+1).
// Signed dividend handling is enabled by defining DIVIDER_SIGNED_EN.
module wallace_tree_divider
  import div_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_start,
  input  logic [2*N-1:0] i_dividend,
  input  logic [N-1:0]   i_divisor,
  output logic           o_busy,
  output logic           o_done,
  output logic [2*N-1:0] o_quotient,
  output logic [N:0]     o_remainder,
  output logic           o_div_by_zero
);
  localparam int W  = 2 * N;
  localparam int CW = $clog2(W + 1);

  state_t         r_state;
  logic [W-1:0]   r_dq;
  logic [N-1:0]   r_div;
  logic [N:0]     r_pr;
  logic [CW-1:0]  r_cnt;
  logic           r_busy;
  logic           r_done;
  logic [W-1:0]   r_quot;
  logic [N:0]     r_rem;
  logic           r_dz;

  logic [W-1:0]   w_mag;
  logic [W-1:0]   w_q_fix;
  logic [N:0]     w_r_fix;
  logic [N:0]     w_pr_next;
  logic           w_qbit;

`ifdef DIVIDER_SIGNED_EN
  logic r_sign;
  assign w_mag   = i_dividend[W-1] ? (~i_dividend + 1'b1) : i_dividend;
  assign w_q_fix = r_sign ? (~r_dq + 1'b1) : r_dq;
  assign w_r_fix = r_sign ? (~r_pr + 1'b1) : r_pr;
`else
  assign w_mag   = i_dividend;
  assign w_q_fix = r_dq;
  assign w_r_fix = r_pr;
`endif

  div_step #(.N(N)) u_step (
    .i_pr      (r_pr[N-1:0]),
    .i_bit     (r_dq[W-1]),
    .i_divisor (r_div),
    .o_pr      (w_pr_next),
    .o_qbit    (w_qbit)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_dq    <= '0;
      r_div   <= '0;
      r_pr    <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_dz    <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      r_sign  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            if (i_divisor == '0) begin
              r_quot <= '1;
              r_rem  <= '0;
              r_dz   <= 1'b1;
              r_done <= 1'b1;
            end else begin
              r_dq    <= w_mag;
              r_div   <= i_divisor;
              r_pr    <= '0;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
              r_state <= CALC;
`ifdef DIVIDER_SIGNED_EN
              r_sign  <= i_dividend[W-1];
`endif
            end
          end
        end
        CALC: begin
          r_dq  <= {r_dq[W-2:0], w_qbit};
          r_pr  <= w_pr_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(W - 1)) r_state <= FIX;
        end
        FIX: begin
          r_quot  <= w_q_fix;
          r_rem   <= w_r_fix;
          r_dz    <= 1'b0;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_quotient    = r_quot;
  assign o_remainder   = r_rem;
  assign o_div_by_zero = r_dz;
endmodule

// File: tb/tb_wallace_tree_divider.sv
// Bench for wallace_tree_divider: directed cases plus randomized traffic,
// checked every cycle against an arithmetic reference of the handshake.
module tb_wallace_tree_divider;
  localparam int N = 4;
  localparam int W = 2 * N;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic         busy, done, dz;
  logic [W-1:0] quot;
  logic [N:0]   rem;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int start_cyc = 0;

  wallace_tree_divider #(.N(N)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_dividend(dividend),
    .i_divisor(divisor), .o_busy(busy), .o_done(done), .o_quotient(quot),
    .o_remainder(rem), .o_div_by_zero(dz)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Truncating division from plain integer arithmetic.
  function automatic void model_div(input logic [W-1:0] a, input logic [N-1:0] b,
                                    output logic [W-1:0] q, output logic [N:0] r);
    int sa, sb, qq, rr;
    sb = int'(b);
`ifdef DIVIDER_SIGNED_EN
    sa = int'($signed(a));
`else
    sa = int'(a);
`endif
    if (sb == 0) begin
      q = '1;
      r = '0;
    end else begin
      qq = sa / sb;
      rr = sa % sb;
      q = qq[W-1:0];
      r = rr[N:0];
    end
  endfunction

  // Reference: an op becomes visible 2N+1 edges after acceptance; div-by-zero at once.
  logic         m_busy = 0, m_done = 0, m_dz = 0;
  logic [W-1:0] m_q = '0, p_q;
  logic [N:0]   m_r = '0, p_r;
  int           m_rem = 0;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_busy = 0; m_done = 0; m_dz = 0; m_q = '0; m_r = '0; m_rem = 0;
      end else begin
        m_done = 0;
        if (m_rem > 0) begin
          m_rem--;
          if (m_rem == 0) begin
            m_busy = 0; m_done = 1; m_dz = 0; m_q = p_q; m_r = p_r;
          end
        end else if (start) begin
          if (divisor == '0) begin
            m_done = 1; m_dz = 1; m_q = '1; m_r = '0;
          end else begin
            model_div(dividend, divisor, p_q, p_r);
            m_busy = 1;
            m_rem = W + 1;
          end
        end
      end
      #1;
      check("cycle {busy,done,dz,q,r}", {busy, done, dz, quot, rem}, {m_busy, m_done, m_dz, m_q, m_r});
    end
  end

  task automatic start_op(input logic [W-1:0] a, input logic [N-1:0] b);
    @(negedge clk);
    start = 1; dividend = a; divisor = b;
    @(negedge clk);
    start = 0;
    start_cyc = cyc;
  endtask

  task automatic wait_done(output int lat, output int bcnt);
    int found;
    lat = -1; bcnt = 0; found = 0;
    for (int j = 0; j <= 30; j++) begin
      if (j > 0) @(negedge clk);
      if (done) begin
        lat = cyc - start_cyc;
        found = 1;
        break;
      end
      if (j > 0 && busy) bcnt++;
    end
    check("done_seen", found, 1);
  endtask

  task automatic do_op(input string name, input logic [W-1:0] a, input logic [N-1:0] b,
                       input logic [W-1:0] eq, input logic [N:0] er, input logic edz,
                       input int elat);
    int lat, bcnt;
    start_op(a, b);
    wait_done(lat, bcnt);
    check({name, " latency"}, lat, elat);
    check({name, " busy cycles"}, bcnt, (elat > 0) ? elat - 1 : 0);
    check({name, " quotient"}, quot, eq);
    check({name, " remainder"}, rem, er);
    check({name, " div_by_zero"}, dz, edz);
  endtask

  logic [W-1:0] tq;
  logic [N:0]   tr;
  int lat, bcnt, seen;

  initial begin
    // Pin the reference model with hand-computed values.
    model_div(8'h64, 4'd7, tq, tr);
    check("model 100/7", {tq, tr}, {8'h0E, 5'b00010});
    model_div(8'h7F, 4'd15, tq, tr);
    check("model 127/15", {tq, tr}, {8'h08, 5'b00111});
    model_div(8'h9C, 4'd7, tq, tr);
`ifdef DIVIDER_SIGNED_EN
    check("model -100/7", {tq, tr}, {8'hF2, 5'b11110});
`else
    check("model 156/7", {tq, tr}, {8'h16, 5'b00010});
`endif

    repeat (3) @(negedge clk);
    check("reset outputs", {busy, done, dz, quot, rem}, '0);
    rst = 0;

    do_op("pos 100/7", 8'h64, 4'd7, 8'h0E, 5'b00010, 0, 9);
`ifdef DIVIDER_SIGNED_EN
    do_op("neg -100/7", 8'h9C, 4'd7, 8'hF2, 5'b11110, 0, 9);
`else
    do_op("uns 156/7", 8'h9C, 4'd7, 8'h16, 5'b00010, 0, 9);
`endif
    do_op("min/1", 8'h80, 4'd1, 8'h80, 5'b00000, 0, 9);
    do_op("127/15", 8'h7F, 4'd15, 8'h08, 5'b00111, 0, 9);
    do_op("div0", 8'h33, 4'd0, 8'hFF, 5'b00000, 1, 0);
    do_op("after div0", 8'h64, 4'd7, 8'h0E, 5'b00010, 0, 9);

    // Reset four cycles into an operation aborts it.
    start_op(8'h64, 4'd7);
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("abort outputs", {busy, done, dz, quot, rem}, '0);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("abort no done", seen, 0);
    do_op("post abort", 8'h64, 4'd7, 8'h0E, 5'b00010, 0, 9);

    // Start while busy with different operands must be ignored.
    start_op(8'h64, 4'd7);
    @(negedge clk);
    start = 1; dividend = 8'h11; divisor = 4'd3;
    @(negedge clk);
    start = 0;
    wait_done(lat, bcnt);
    check("ignored start latency", lat, 9);
    check("ignored start result", {quot, rem}, {8'h0E, 5'b00010});

    // Start raised in the done cycle is accepted back-to-back.
    start = 1; dividend = 8'h7F; divisor = 4'd15;
    @(negedge clk);
    start = 0;
    start_cyc = cyc;
    wait_done(lat, bcnt);
    check("back-to-back latency", lat, 9);
    check("back-to-back result", {quot, rem}, {8'h08, 5'b00111});

    // Random traffic, checked cycle by cycle by the reference.
    repeat (1500) begin
      @(negedge clk);
      start    = ($urandom_range(0, 2) == 0);
      dividend = W'($urandom);
      divisor  = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
      rst      = ($urandom_range(0, 149) == 0);
    end
    @(negedge clk);
    start = 0; rst = 0;
    repeat (12) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
